// File: rtl/pipe_ir_chain_pkg.sv
// Shared constants, field helpers and edge-action encoding for the
// instruction-register chain and its hazard detector.
package pipe_ir_chain_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] iword_t;

    localparam logic [5:0] LOAD_OP  = 6'h12;
    localparam iword_t     NOP_WORD = 32'h0000_0000;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    // Bit positions inside stage_vld = {mw, em, ie, ii}.
    localparam int II = 0;
    localparam int IE = 1;
    localparam int EM = 2;
    localparam int MW = 3;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } stage_act_e;

    function automatic logic [5:0] op_of(input iword_t w);
        return w[OP_HI:OP_LO];
    endfunction

    function automatic logic [4:0] rs_of(input iword_t w);
        return w[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_of(input iword_t w);
        return w[RT_HI:RT_LO];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Combinational load-use detector: a valid load in ID/EX whose non-zero rt
// feeds a valid instruction in IF/ID. Suppressed by branch flush and hold.
module pipe_hazard_det
    import pipe_ir_chain_pkg::*;
(
    input  logic [31:0] ii_word,
    input  logic [31:0] ie_word,
    input  logic        ii_vld,
    input  logic        ie_vld,
    input  logic        branch_taken,
    input  logic        hold,
    output logic        stall
);

    logic       ie_is_load;
    logic [4:0] ie_rt;
    logic       rt_match;
    logic       unused_bits;

    assign ie_is_load = (op_of(ie_word) == LOAD_OP);
    assign ie_rt      = rt_of(ie_word);
    assign rt_match   = (ie_rt == rs_of(ii_word)) | (ie_rt == rt_of(ii_word));

    // A squashed or frozen pair never requests a bubble.
    assign stall = ie_vld & ie_is_load & (ie_rt != 5'd0) & ii_vld & rt_match
                 & ~branch_taken & ~hold;

    // Only opcode/register fields take part in detection.
    assign unused_bits = ^{ii_word[OP_HI:OP_LO], ii_word[RT_LO-1:0],
                           ie_word[RS_HI:RS_LO], ie_word[RT_LO-1:0]};

endmodule

// File: rtl/pipe_ir_chain.sv
// IF/ID -> ID/EX -> EX/MEM -> MEM/WB instruction-register chain with
// load-use bubbles, branch squash and global hold. Optional PIPE_STATS_EN
// adds saturating stall/flush counters.
module pipe_ir_chain
    import pipe_ir_chain_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        branch_taken,
    input  logic        hold,
    output logic [31:0] iiO,
    output logic [31:0] ieO,
    output logic [31:0] emO,
    output logic [31:0] mwO,
    output logic [3:0]  stage_vld,
    output logic        stall,
    output logic        pc_we
`ifdef PIPE_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    iword_t     ii_q, ie_q, em_q, mw_q;
    logic [3:0] vld_q;
    stage_act_e act;

    pipe_hazard_det u_hazard (
        .ii_word      (ii_q),
        .ie_word      (ie_q),
        .ii_vld       (vld_q[II]),
        .ie_vld       (vld_q[IE]),
        .branch_taken (branch_taken),
        .hold         (hold),
        .stall        (stall)
    );

    assign pc_we = ~hold & ~stall;

    // NOTE: act gets its default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        act = ACT_NORMAL;
        if (hold)
            act = ACT_HOLD;
        else if (branch_taken)
            act = ACT_FLUSH;
        else if (stall)
            act = ACT_STALL;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its upstream neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            ii_q  <= NOP_WORD;
            ie_q  <= NOP_WORD;
            em_q  <= NOP_WORD;
            mw_q  <= NOP_WORD;
            vld_q <= 4'b0000;
        end else begin
            case (act)
                ACT_HOLD: begin
                    ii_q  <= ii_q;
                    ie_q  <= ie_q;
                    em_q  <= em_q;
                    mw_q  <= mw_q;
                    vld_q <= vld_q;
                end
                ACT_FLUSH: begin
                    ii_q      <= NOP_WORD;
                    ie_q      <= NOP_WORD;
                    em_q      <= ie_q;
                    mw_q      <= em_q;
                    vld_q[II] <= 1'b0;
                    vld_q[IE] <= 1'b0;
                    vld_q[EM] <= vld_q[IE];
                    vld_q[MW] <= vld_q[EM];
                end
                ACT_STALL: begin
                    // IF/ID keeps the dependent instruction; the bubble
                    // in ID/EX clears the hazard on the next cycle.
                    ii_q      <= ii_q;
                    ie_q      <= NOP_WORD;
                    em_q      <= ie_q;
                    mw_q      <= em_q;
                    vld_q[II] <= vld_q[II];
                    vld_q[IE] <= 1'b0;
                    vld_q[EM] <= vld_q[IE];
                    vld_q[MW] <= vld_q[EM];
                end
                default: begin
                    ii_q      <= instr_in;
                    ie_q      <= ii_q;
                    em_q      <= ie_q;
                    mw_q      <= em_q;
                    vld_q[II] <= 1'b1;
                    vld_q[IE] <= vld_q[II];
                    vld_q[EM] <= vld_q[IE];
                    vld_q[MW] <= vld_q[EM];
                end
            endcase
        end
    end

    assign iiO       = ii_q;
    assign ieO       = ie_q;
    assign emO       = em_q;
    assign mwO       = mw_q;
    assign stage_vld = vld_q;

`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall)
                stall_cnt_q <= sat_inc16(stall_cnt_q);
            if (branch_taken && !hold)
                flush_cnt_q <= sat_inc16(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ir_chain.sv
// Bench for pipe_ir_chain: a vector table for the directed corner cases plus
// a queue scoreboard over a random hazard-free stream with random holds.
module tb_pipe_ir_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        branch_taken;
    logic        hold;
    logic [31:0] iiO, ieO, emO, mwO;
    logic [3:0]  stage_vld;
    logic        stall;
    logic        pc_we;
`ifdef PIPE_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ir_chain dut (
        .clk          (clk),
        .rst          (rst),
        .instr_in     (instr_in),
        .branch_taken (branch_taken),
        .hold         (hold),
        .iiO          (iiO),
        .ieO          (ieO),
        .emO          (emO),
        .mwO          (mwO),
        .stage_vld    (stage_vld),
        .stall        (stall),
        .pc_we        (pc_we)
`ifdef PIPE_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        hold;
        logic        br;
        logic [31:0] instr;
        logic        chk_pre;
        logic        stall;
        logic        pc_we;
        logic [31:0] ii, ie, em, mw;
        logic [3:0]  vld;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] A = 32'h0010_0000, B = 32'h0410_0000;
    localparam logic [31:0] C = 32'h0810_0000, D = 32'h1400_0000;
    localparam logic [31:0] L = 32'h4822_0000, U = 32'h0040_0000;
    localparam logic [31:0] E = 32'h2C00_0000, Z = 32'h4820_0000;
    localparam logic [31:0] G = 32'h2400_0000, F = 32'h2800_0000;
    localparam logic [31:0] H = 32'h3000_0000, N = 32'h0000_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic h, input logic b, input logic [31:0] ins,
                       input logic cp, input logic st, input logic pw,
                       input logic [31:0] ii, input logic [31:0] ie, input logic [31:0] em,
                       input logic [31:0] mw, input logic [3:0] v,
                       input logic [15:0] sc, input logic [15:0] fc);
        vec_t t;
        t.rst = r; t.hold = h; t.br = b; t.instr = ins;
        t.chk_pre = cp; t.stall = st; t.pc_we = pw;
        t.ii = ii; t.ie = ie; t.em = em; t.mw = mw; t.vld = v;
        t.sc = sc; t.fc = fc;
        vecs.push_back(t);
    endtask

    int          pushed, popped;
    logic [31:0] w, exp_w;
    logic        h;

    initial begin
        rst = 1'b1; hold = 1'b0; branch_taken = 1'b0; instr_in = N;

        //   rst hold br instr  pre stall pcwe   ii  ie  em  mw  vld      sc fc
        add(1, 0, 0, N,   0, 0, 1,   N, N, N, N, 4'b0000, 0, 0); // 0 reset
        add(1, 0, 0, N,   1, 0, 1,   N, N, N, N, 4'b0000, 0, 0); // 1
        add(0, 0, 0, A,   1, 0, 1,   A, N, N, N, 4'b0001, 0, 0); // 2 fill
        add(0, 0, 0, B,   1, 0, 1,   B, A, N, N, 4'b0011, 0, 0); // 3
        add(0, 0, 0, C,   1, 0, 1,   C, B, A, N, 4'b0111, 0, 0); // 4
        add(0, 0, 0, D,   1, 0, 1,   D, C, B, A, 4'b1111, 0, 0); // 5
        add(0, 0, 0, L,   1, 0, 1,   L, D, C, B, 4'b1111, 0, 0); // 6 load-use
        add(0, 0, 0, U,   1, 0, 1,   U, L, D, C, 4'b1111, 0, 0); // 7
        add(0, 0, 0, H,   1, 1, 0,   U, N, L, D, 4'b1101, 1, 0); // 8 stall
        add(0, 0, 0, E,   1, 0, 1,   E, U, N, L, 4'b1011, 1, 0); // 9
        add(0, 0, 0, Z,   1, 0, 1,   Z, E, U, N, 4'b0111, 1, 0); // 10 rt=0 load
        add(0, 0, 0, N,   1, 0, 1,   N, Z, E, U, 4'b1111, 1, 0); // 11
        add(0, 0, 0, G,   1, 0, 1,   G, N, Z, E, 4'b1111, 1, 0); // 12 no stall
        add(0, 0, 0, F,   1, 0, 1,   F, G, N, Z, 4'b1111, 1, 0); // 13
        add(0, 0, 1, H,   1, 0, 1,   N, N, G, N, 4'b1100, 1, 1); // 14 flush
        add(0, 0, 0, L,   1, 0, 1,   L, N, N, G, 4'b1001, 1, 1); // 15
        add(0, 0, 0, U,   1, 0, 1,   U, L, N, N, 4'b0011, 1, 1); // 16
        add(0, 0, 1, H,   1, 0, 1,   N, N, L, N, 4'b0100, 1, 2); // 17 flush beats stall
        add(0, 0, 0, L,   1, 0, 1,   L, N, N, L, 4'b1001, 1, 2); // 18
        add(0, 0, 0, U,   1, 0, 1,   U, L, N, N, 4'b0011, 1, 2); // 19
        add(0, 1, 0, H,   1, 0, 0,   U, L, N, N, 4'b0011, 1, 2); // 20 hold x3
        add(0, 1, 0, H,   1, 0, 0,   U, L, N, N, 4'b0011, 1, 2); // 21
        add(0, 1, 0, H,   1, 0, 0,   U, L, N, N, 4'b0011, 1, 2); // 22
        add(0, 0, 0, H,   1, 1, 0,   U, N, L, N, 4'b0101, 2, 2); // 23 stall once
        add(0, 0, 0, H,   1, 0, 1,   H, U, N, L, 4'b1011, 2, 2); // 24
        add(1, 0, 0, E,   1, 0, 1,   N, N, N, N, 4'b0000, 0, 0); // 25 mid reset
        add(0, 0, 0, A,   1, 0, 1,   A, N, N, N, 4'b0001, 0, 0); // 26

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            hold         = vecs[i].hold;
            branch_taken = vecs[i].br;
            instr_in     = vecs[i].instr;
            #1;
            if (vecs[i].chk_pre) begin
                check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].stall});
                check($sformatf("v%0d pc_we", i), {31'b0, pc_we}, {31'b0, vecs[i].pc_we});
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d iiO", i), iiO, vecs[i].ii);
            check($sformatf("v%0d ieO", i), ieO, vecs[i].ie);
            check($sformatf("v%0d emO", i), emO, vecs[i].em);
            check($sformatf("v%0d mwO", i), mwO, vecs[i].mw);
            check($sformatf("v%0d vld", i), {28'b0, stage_vld}, {28'b0, vecs[i].vld});
`ifdef PIPE_STATS_EN
            check($sformatf("v%0d stall_cnt", i), {16'b0, stall_cnt}, {16'b0, vecs[i].sc});
            check($sformatf("v%0d flush_cnt", i), {16'b0, flush_cnt}, {16'b0, vecs[i].fc});
`endif
        end

        // Random non-load stream with random holds; every accepted word must
        // reach MEM/WB in order.
        rst = 1'b1; hold = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 60; c++) begin
            w = {6'($urandom_range(0, 17)), 26'($urandom)};
            h = ($urandom_range(0, 3) == 0);
            instr_in = w;
            hold     = h;
            if (!h) begin
                exp_q.push_back(w);
                pushed++;
            end
            @(posedge clk);
            #1;
            if (!h && stage_vld[3]) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    exp_w = exp_q.pop_front();
                    check($sformatf("sb c%0d mwO", c), mwO, exp_w);
                    popped++;
                end
            end
        end
        check("sb_in_flight", exp_q.size(), 32'd3);
        check("sb_popped", popped, pushed - 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ir_chain.md
Name: pipe_ir_chain

Overview:
Pipeline instruction-register chain that feeds the control unit. It carries each fetched instruction word through the IF/ID, ID/EX, EX/MEM and MEM/WB stages and drives those words as iiO/ieO/emO/mwO. It detects load-use hazards, inserts bubbles, squashes younger stages on taken branches, and honours a global hold.

Parameters:
LOAD_OP, 6'h12, opcode[31:26] of the load instruction, used for load-use detection.
NOP_WORD, 32'h00000000, bubble word injected on stall or flush.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
instr_in  input  32  word from instruction memory at the current PC.
branch_taken  input  1  a branch in EX resolved taken (from control unit/zero).
hold  input  1  global freeze, e.g. memory wait.
iiO  output  32  IF/ID instruction register.
ieO  output  32  ID/EX instruction register.
emO  output  32  EX/MEM instruction register.
mwO  output  32  MEM/WB instruction register.
stage_vld  output  4  valid bits {mw,em,ie,ii}; 0 marks a bubble.
stall  output  1  combinational load-use hazard indication.
pc_we  output  1  PC write enable.

Behaviour:
- Reset (rst=1 at an edge): iiO/ieO/emO/mwO <= NOP_WORD, stage_vld <= 4'b0000. rst overrides all other inputs.
- Field slices: op=[31:26], rs=[25:21], rt=[20:16].
- Hazard, combinational: stall = stage_vld[1] & (ieO.op==LOAD_OP) & (ieO.rt!=0) & stage_vld[0] & ((ieO.rt==iiO.rs) | (ieO.rt==iiO.rt)). It is forced to 0 when branch_taken=1 or hold=1.
- pc_we = ~hold & ~stall. A flush does not clear pc_we; the PC mux loads the target.
- Edge priority: rst > hold > branch_taken > stall > normal.
  - hold: all four registers and stage_vld keep their values.
  - flush (branch_taken): iiO <= NOP, ieO <= NOP, and their valid bits <= 0. emO <= ieO and mwO <= emO with their valid bits.
  - stall: iiO holds and its valid bit holds. ieO <= NOP with valid 0. emO and mwO advance.
  - normal: iiO <= instr_in with valid 1, ieO <= iiO, emO <= ieO, mwO <= emO. Valid bits shift with the data.
- Latency: an instruction appears on iiO one cycle after it is presented, and on mwO four cycles after it is presented, plus one cycle per stall or hold.
- A stall lasts exactly one cycle, because the bubble in ID/EX clears the hazard. A hold during a stall extends it with no double bubble.
- A flush with a simultaneous hazard is a flush only; the squashed instruction cannot stall.
- Deasserting rst mid-stream: the first edge after deassertion behaves as normal from the all-NOP state.

Optional Feature:
PIPE_STATS_EN
- Defined: two extra outputs, stall_cnt[15:0] and flush_cnt[15:0]. Each is reset to 0 by rst. Each increments on every edge where stall=1 (resp. branch_taken=1 and hold=0). Both saturate at 16'hFFFF. hold-only cycles are not counted.
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package holds NOP_WORD, LOAD_OP, the field-slice constants (OP_HI/LO, RS_HI/LO, RT_HI/LO) and the stage-index constants II/IE/EM/MW for stage_vld.
- One natural combinational sub-module, pipe_hazard_det: inputs iiO, ieO, the two valid bits, branch_taken and hold; output stall.
- The registers and priority mux stay in pipe_ir_chain.

Test Plan:
- Reset/fill: rst for 2 cycles, then feed 32'h00100000, 32'h04100000, 32'h08100000, 32'h14000000 on successive cycles -> after the 4th edge mwO=32'h00100000 and emO=32'h04100000; stage_vld goes 0001, 0011, 0111, 1111.
- Load-use: feed 32'h48220000 (load, rt=2) then 32'h00400000 (rs=2) -> when the load is in ieO, stall=1 and pc_we=0. Next edge: ieO=NOP, iiO still 32'h00400000, emO=32'h48220000, stall=0.
- No hazard on rt=0: load 32'h48200000 then 32'h00000000 -> stall stays 0.
- Flush: branch_taken=1 for one cycle while iiO=32'h28000000 and ieO=32'h24000000 -> iiO=ieO=NOP with valid bits 0; emO receives the prior ieO. With PIPE_STATS_EN, flush_cnt=1.
- Flush beats stall: load-use condition present and branch_taken=1 -> stall=0, both younger stages become NOP, pc_we=1.
- Hold during stall: set a load-use condition, hold=1 for 3 cycles -> all registers frozen, stall=0, pc_we=0. Release hold -> stall=1 for one cycle; stall_cnt increments by exactly 1.
